// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle instruction sequencer:
// FSM state encoding, RV32 opcode constants, branch funct3 codes and
// the legality check applied in DECODE.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 010/011 have no branch meaning and are treated as illegal.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE: ok = 1'b1;
      OP_BRANCH:                     ok = (f3 != 3'b010) && (f3 != 3'b011);
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer bus: instruction/memory handshake, comparator inputs and
// datapath control strobes.
//   slave  : the sequencer side (drives the control strobes)
//   master : the datapath/memory side (drives IWord, mem_ready, BrEq, BrLt)
interface multicycle_sequencer_if;
  logic [31:0] IWord;
  logic        mem_ready;
  logic        BrEq;
  logic        BrLt;
  logic        mem_req;
  logic        mem_we;
  logic        ir_we;
  logic        pc_we;
  logic        RegWEn;
  logic        PCSelect;
  logic        BrUn;
  logic        halt;
  logic [15:0] instret;
  logic [2:0]  state;

  modport slave (
    input  IWord, mem_ready, BrEq, BrLt,
    output mem_req, mem_we, ir_we, pc_we, RegWEn, PCSelect, BrUn,
           halt, instret, state
  );

  modport master (
    output IWord, mem_ready, BrEq, BrLt,
    input  mem_req, mem_we, ir_we, pc_we, RegWEn, PCSelect, BrUn,
           halt, instret, state
  );
endinterface

// File: rtl/multicycle_sequencer_branch_resolve.sv
// Branch outcome decode from the latched funct3 and comparator results.
//   funct3_i : latched branch funct3
//   br_eq_i  : rs1 == rs2
//   br_lt_i  : rs1 <  rs2 (signedness chosen by br_un_o)
//   take_o   : branch taken
//   br_un_o  : unsigned compare request (funct3[1])
module branch_resolve
  import multicycle_sequencer_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       take_o,
  output logic       br_un_o
);

  always_comb begin
    take_o = 1'b0;
    case (funct3_i)
      F3_BEQ:           take_o = br_eq_i;
      F3_BNE:           take_o = ~br_eq_i;
      F3_BLT, F3_BLTU:  take_o = br_lt_i;
      F3_BGE, F3_BGEU:  take_o = ~br_lt_i;
      default:          take_o = 1'b0;
    endcase
  end

  assign br_un_o = funct3_i[1];

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sequencer bus (slave side), see multicycle_sequencer_if
//
// state  | meaning
// FETCH  | request instruction, latch opcode/funct3 on mem_ready
// DECODE | one cycle legality check
// EXEC   | execute; branches resolve and retire here
// MEM    | load/store access, wait on mem_ready
// WB     | register write-back, PC+4, retire
// HALT   | illegal instruction, left only by reset
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_sequencer_if.slave bus
);

  state_e      state_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [15:0] instret_q;
  // Cleared by reset, set on the first edge afterwards: keeps every strobe,
  // including the FETCH request, low while reset is asserted.
  logic        active_q;

  logic is_branch, is_store, is_mem;
  logic take, br_un;
  logic retire;
  logic unused_iword;

  assign unused_iword = ^{bus.IWord[31:15], bus.IWord[11:7]};

  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_mem    = (opcode_q == OP_LOAD) || is_store;

  branch_resolve u_branch_resolve (
    .funct3_i (funct3_q),
    .br_eq_i  (bus.BrEq),
    .br_lt_i  (bus.BrLt),
    .take_o   (take),
    .br_un_o  (br_un)
  );

  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_EXEC: retire = is_branch;
      ST_MEM:  retire = is_store && bus.mem_ready;
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      instret_q <= 16'd0;
      active_q  <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (retire) instret_q <= instret_q + 16'd1;
      case (state_q)
        ST_FETCH: begin
          if (active_q && bus.mem_ready) begin
            opcode_q <= bus.IWord[6:0];
            funct3_q <= bus.IWord[14:12];
            state_q  <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= is_legal(opcode_q, funct3_q) ? ST_EXEC : ST_HALT;
        ST_EXEC: begin
          if (is_branch)   state_q <= ST_FETCH;
          else if (is_mem) state_q <= ST_MEM;
          else             state_q <= ST_WB;
        end
        ST_MEM: begin
          if (bus.mem_ready) state_q <= is_store ? ST_FETCH : ST_WB;
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Strobes are decoded from registered state; the memory-completion
  // strobes additionally see mem_ready so a ready in the first request
  // cycle completes at once.
  assign bus.mem_req  = active_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign bus.mem_we   = (state_q == ST_MEM) && is_store;
  assign bus.ir_we    = active_q && (state_q == ST_FETCH) && bus.mem_ready;
  assign bus.pc_we    = retire;
  assign bus.RegWEn   = (state_q == ST_WB);
  assign bus.PCSelect = (state_q == ST_EXEC) && is_branch && take;
  assign bus.BrUn     = (state_q == ST_EXEC) && br_un;
  assign bus.halt     = (state_q == ST_HALT);
  assign bus.instret  = instret_q;
  assign bus.state    = state_q;

endmodule
